// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS control units: opcodes, ALU/mux selects,
// multi-cycle FSM states and the bundled control word.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_SUB    = 2'b01,
    ALU_R_TYPE = 2'b10
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_REG     = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pc_source_e;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_RD    = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WR    = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BEQ       = 4'd9,
    S_JMP       = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12,
    S_HALT      = 4'd13
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_2_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    alu_src_b_e alu_src_b;
    alu_op_e    alu_op;
    pc_source_e pc_source;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM with memory-ready stalls, illegal-opcode
// trapping and a retired-instruction counter.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W        = 32,
  parameter bit          ILLEGAL_HALT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_2_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       pc_source,
  output logic             illegal_op,
  output logic             halted,
  output logic [CNT_W-1:0] instr_retired,
  output logic [3:0]       state
);

  state_e           state_q, state_d;
  logic             illegal_op_q, illegal_op_d;
  logic [CNT_W-1:0] retired_q;
  logic             retire;
  ctrl_t            ctl;

  // NOTE: every variable written here gets a default first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    illegal_op_d = 1'b0;
    retire       = 1'b0;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_BEQ:       state_d = S_BEQ;
          OP_J:         state_d = S_JMP;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          default: begin
            illegal_op_d = 1'b1;
            state_d      = ILLEGAL_HALT ? S_HALT : S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:    if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WR: begin
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_MEM_WB, S_R_WB, S_BEQ, S_JMP, S_ADDI_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_R_EXEC:    state_d = S_R_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_IDLE;
    endcase
  end

  // Decode is gated by rst so that no enable can pulse while reset is asserted.
  always_comb begin
    ctl = '0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          ctl.mem_read  = 1'b1;
          ctl.alu_src_b = SRCB_FOUR;
          ctl.ir_write  = mem_ready;
          ctl.pc_write  = mem_ready;
        end
        S_DECODE: ctl.alu_src_b = SRCB_IMM_SH2;
        S_MEM_ADDR, S_ADDI_EXEC: begin
          ctl.alu_src_a = 1'b1;
          ctl.alu_src_b = SRCB_IMM;
        end
        S_MEM_RD: begin
          ctl.mem_read = 1'b1;
          ctl.iord     = 1'b1;
        end
        S_MEM_WB: begin
          ctl.reg_write = 1'b1;
          ctl.mem_2_reg = 1'b1;
        end
        S_MEM_WR: begin
          ctl.mem_write = 1'b1;
          ctl.iord      = 1'b1;
        end
        S_R_EXEC: begin
          ctl.alu_src_a = 1'b1;
          ctl.alu_op    = ALU_R_TYPE;
        end
        S_R_WB: begin
          ctl.reg_write = 1'b1;
          ctl.reg_dst   = 1'b1;
        end
        S_BEQ: begin
          ctl.alu_src_a     = 1'b1;
          ctl.alu_op        = ALU_SUB;
          ctl.pc_write_cond = 1'b1;
          ctl.pc_source     = PCSRC_ALUOUT;
        end
        S_JMP: begin
          ctl.pc_write  = 1'b1;
          ctl.pc_source = PCSRC_JUMP;
        end
        S_ADDI_WB: ctl.reg_write = 1'b1;
        S_HALT:    ctl.halted    = 1'b1;
        default:   ctl = '0;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      illegal_op_q <= 1'b0;
      retired_q    <= '0;
    end else begin
      state_q      <= state_d;
      illegal_op_q <= illegal_op_d;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign pc_write      = ctl.pc_write;
  assign pc_write_cond = ctl.pc_write_cond;
  assign iord          = ctl.iord;
  assign mem_read      = ctl.mem_read;
  assign mem_write     = ctl.mem_write;
  assign ir_write      = ctl.ir_write;
  assign mem_2_reg     = ctl.mem_2_reg;
  assign reg_dst       = ctl.reg_dst;
  assign reg_write     = ctl.reg_write;
  assign alu_src_a     = ctl.alu_src_a;
  assign alu_src_b     = ctl.alu_src_b;
  assign alu_op        = ctl.alu_op;
  assign pc_source     = ctl.pc_source;
  assign halted        = ctl.halted;
  assign illegal_op    = illegal_op_q;
  assign instr_retired = retired_q;
  assign state         = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: three instances (halt-on-illegal,
// drop-illegal, 4-bit counter) share the stimulus.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       mem_ready;

  always #5 clk = ~clk;

  wire        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  wire        mem_2_reg, reg_dst, reg_write, alu_src_a, illegal_op, halted;
  wire [1:0]  alu_src_b, alu_op, pc_source;
  wire [31:0] instr_retired;
  wire [3:0]  state;

  wire        pc_write_n, pc_write_cond_n, iord_n, mem_read_n, mem_write_n, ir_write_n;
  wire        mem_2_reg_n, reg_dst_n, reg_write_n, alu_src_a_n, illegal_op_n, halted_n;
  wire [1:0]  alu_src_b_n, alu_op_n, pc_source_n;
  wire [31:0] instr_retired_n;
  wire [3:0]  state_n;

  wire        pc_write_w, pc_write_cond_w, iord_w, mem_read_w, mem_write_w, ir_write_w;
  wire        mem_2_reg_w, reg_dst_w, reg_write_w, alu_src_a_w, illegal_op_w, halted_w;
  wire [1:0]  alu_src_b_w, alu_op_w, pc_source_w;
  wire [3:0]  instr_retired_w;
  wire [3:0]  state_w;

  multicycle_ctrl #(.CNT_W(32), .ILLEGAL_HALT(1'b1)) u_dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_2_reg(mem_2_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .halted(halted),
    .instr_retired(instr_retired), .state(state)
  );

  multicycle_ctrl #(.CNT_W(32), .ILLEGAL_HALT(1'b0)) u_dut_n (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write_n), .pc_write_cond(pc_write_cond_n), .iord(iord_n),
    .mem_read(mem_read_n), .mem_write(mem_write_n), .ir_write(ir_write_n),
    .mem_2_reg(mem_2_reg_n), .reg_dst(reg_dst_n), .reg_write(reg_write_n),
    .alu_src_a(alu_src_a_n), .alu_src_b(alu_src_b_n), .alu_op(alu_op_n),
    .pc_source(pc_source_n), .illegal_op(illegal_op_n), .halted(halted_n),
    .instr_retired(instr_retired_n), .state(state_n)
  );

  multicycle_ctrl #(.CNT_W(4), .ILLEGAL_HALT(1'b1)) u_dut_w (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write_w), .pc_write_cond(pc_write_cond_w), .iord(iord_w),
    .mem_read(mem_read_w), .mem_write(mem_write_w), .ir_write(ir_write_w),
    .mem_2_reg(mem_2_reg_w), .reg_dst(reg_dst_w), .reg_write(reg_write_w),
    .alu_src_a(alu_src_a_w), .alu_src_b(alu_src_b_w), .alu_op(alu_op_w),
    .pc_source(pc_source_w), .illegal_op(illegal_op_w), .halted(halted_w),
    .instr_retired(instr_retired_w), .state(state_w)
  );

  // Control word: pc_write,pc_write_cond,iord,mem_read,mem_write,ir_write,
  // mem_2_reg,reg_dst,reg_write,alu_src_a,alu_src_b[1:0],alu_op[1:0],pc_source[1:0]
  wire [15:0] ctl   = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                       mem_2_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
  wire [15:0] ctl_n = {pc_write_n, pc_write_cond_n, iord_n, mem_read_n, mem_write_n, ir_write_n,
                       mem_2_reg_n, reg_dst_n, reg_write_n, alu_src_a_n, alu_src_b_n, alu_op_n,
                       pc_source_n};
  wire [15:0] ctl_w = {pc_write_w, pc_write_cond_w, iord_w, mem_read_w, mem_write_w, ir_write_w,
                       mem_2_reg_w, reg_dst_w, reg_write_w, alu_src_a_w, alu_src_b_w, alu_op_w,
                       pc_source_w};

  localparam logic [15:0] C_IDLE       = 16'h0000;
  localparam logic [15:0] C_FETCH_RDY  = 16'h9410;
  localparam logic [15:0] C_FETCH_WAIT = 16'h1010;
  localparam logic [15:0] C_DECODE     = 16'h0030;
  localparam logic [15:0] C_MEM_ADDR   = 16'h0060;
  localparam logic [15:0] C_MEM_RD     = 16'h3000;
  localparam logic [15:0] C_MEM_WB     = 16'h0280;
  localparam logic [15:0] C_MEM_WR     = 16'h2800;
  localparam logic [15:0] C_R_EXEC     = 16'h0048;
  localparam logic [15:0] C_R_WB       = 16'h0180;
  localparam logic [15:0] C_BEQ        = 16'h4045;
  localparam logic [15:0] C_JMP        = 16'h8002;
  localparam logic [15:0] C_ADDI_EXEC  = 16'h0060;
  localparam logic [15:0] C_ADDI_WB    = 16'h0080;

  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEM_ADDR = 4'd3,
                         S_MEM_RD = 4'd4, S_MEM_WB = 4'd5, S_MEM_WR = 4'd6, S_R_EXEC = 4'd7,
                         S_R_WB = 4'd8, S_BEQ = 4'd9, S_JMP = 4'd10, S_ADDI_EXEC = 4'd11,
                         S_ADDI_WB = 4'd12, S_HALT = 4'd13;

  int n_checks = 0;
  int n_pass   = 0;

  logic [3:0]  exp_st  [64];
  logic [15:0] exp_ctl [64];
  logic [5:0]  op_v    [64];
  logic        rdy_v   [64];
  logic [3:0]  obs_st  [64];
  logic [15:0] obs_ctl [64];
  logic [31:0] obs_ret [64];
  int          n_steps;

  task automatic add_step(input logic [3:0] st, input logic [15:0] c,
                          input logic [5:0] op, input logic r);
    exp_st[n_steps]  = st;
    exp_ctl[n_steps] = c;
    op_v[n_steps]    = op;
    rdy_v[n_steps]   = r;
    n_steps++;
  endtask

  // Drives one table row per cycle and records what the DUT shows mid-cycle.
  task automatic play();
    for (int i = 0; i < n_steps; i++) begin
      opcode    = op_v[i];
      mem_ready = rdy_v[i];
      #1;
      obs_st[i]  = state;
      obs_ctl[i] = ctl;
      obs_ret[i] = instr_retired;
      if (i != n_steps - 1) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; opcode = 6'h00; mem_ready = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (state !== S_IDLE) $display("FAIL reset_state: got %0d want 0", state); else n_pass++;
    n_checks++; if (ctl !== C_IDLE) $display("FAIL reset_ctl: got %h want 0000", ctl); else n_pass++;
    n_checks++; if (instr_retired !== 32'd0) $display("FAIL reset_cnt: got %0d want 0", instr_retired); else n_pass++;
    n_checks++; if ({illegal_op, halted} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {illegal_op, halted}); else n_pass++;
    n_checks++; if ({state_n, state_w, instr_retired_w} !== 12'h000) $display("FAIL reset_others: got %h want 000", {state_n, state_w, instr_retired_w}); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_add();
    n_steps = 0;
    add_step(S_IDLE,   C_IDLE,      6'h00, 1'b1);
    add_step(S_FETCH,  C_FETCH_RDY, 6'h00, 1'b1);
    add_step(S_DECODE, C_DECODE,    6'h00, 1'b1);
    add_step(S_R_EXEC, C_R_EXEC,    6'h00, 1'b1);
    add_step(S_R_WB,   C_R_WB,      6'h00, 1'b1);
    add_step(S_FETCH,  C_FETCH_RDY, 6'h00, 1'b1);
    play();
    for (int i = 0; i < n_steps; i++) begin
      n_checks++;
      if (obs_st[i] !== exp_st[i] || obs_ctl[i] !== exp_ctl[i])
        $display("FAIL add_step%0d: got state=%0d ctl=%h want state=%0d ctl=%h",
                 i, obs_st[i], obs_ctl[i], exp_st[i], exp_ctl[i]);
      else n_pass++;
    end
    n_checks++; if (obs_ret[4] !== 32'd0) $display("FAIL add_cnt_before: got %0d want 0", obs_ret[4]); else n_pass++;
    n_checks++; if (obs_ret[5] !== 32'd1) $display("FAIL add_cnt_after: got %0d want 1", obs_ret[5]); else n_pass++;
  endtask

  task automatic test_lw_stall();
    n_steps = 0;
    add_step(S_FETCH,    C_FETCH_RDY, 6'h23, 1'b1);
    add_step(S_DECODE,   C_DECODE,    6'h23, 1'b0);
    add_step(S_MEM_ADDR, C_MEM_ADDR,  6'h23, 1'b0);
    add_step(S_MEM_RD,   C_MEM_RD,    6'h23, 1'b0);
    add_step(S_MEM_RD,   C_MEM_RD,    6'h23, 1'b0);
    add_step(S_MEM_RD,   C_MEM_RD,    6'h23, 1'b0);
    add_step(S_MEM_RD,   C_MEM_RD,    6'h23, 1'b1);
    add_step(S_MEM_WB,   C_MEM_WB,    6'h23, 1'b1);
    add_step(S_FETCH,    C_FETCH_RDY, 6'h23, 1'b1);
    play();
    for (int i = 0; i < n_steps; i++) begin
      n_checks++;
      if (obs_st[i] !== exp_st[i] || obs_ctl[i] !== exp_ctl[i])
        $display("FAIL lw_step%0d: got state=%0d ctl=%h want state=%0d ctl=%h",
                 i, obs_st[i], obs_ctl[i], exp_st[i], exp_ctl[i]);
      else n_pass++;
    end
    n_checks++; if (obs_ret[8] !== 32'd2) $display("FAIL lw_cnt: got %0d want 2", obs_ret[8]); else n_pass++;
  endtask

  task automatic test_back_to_back();
    n_steps = 0;
    add_step(S_FETCH,    C_FETCH_WAIT, 6'h2B, 1'b0);
    add_step(S_FETCH,    C_FETCH_RDY,  6'h2B, 1'b1);
    add_step(S_DECODE,   C_DECODE,     6'h2B, 1'b1);
    add_step(S_MEM_ADDR, C_MEM_ADDR,   6'h2B, 1'b1);
    add_step(S_MEM_WR,   C_MEM_WR,     6'h2B, 1'b0);
    add_step(S_MEM_WR,   C_MEM_WR,     6'h2B, 1'b1);
    add_step(S_FETCH,    C_FETCH_RDY,  6'h04, 1'b1);
    add_step(S_DECODE,   C_DECODE,     6'h04, 1'b1);
    add_step(S_BEQ,      C_BEQ,        6'h04, 1'b1);
    add_step(S_FETCH,    C_FETCH_RDY,  6'h02, 1'b1);
    add_step(S_DECODE,   C_DECODE,     6'h02, 1'b1);
    add_step(S_JMP,      C_JMP,        6'h02, 1'b1);
    add_step(S_FETCH,    C_FETCH_RDY,  6'h02, 1'b1);
    play();
    for (int i = 0; i < n_steps; i++) begin
      n_checks++;
      if (obs_st[i] !== exp_st[i] || obs_ctl[i] !== exp_ctl[i])
        $display("FAIL b2b_step%0d: got state=%0d ctl=%h want state=%0d ctl=%h",
                 i, obs_st[i], obs_ctl[i], exp_st[i], exp_ctl[i]);
      else n_pass++;
    end
    n_checks++; if (obs_ret[12] !== 32'd5) $display("FAIL b2b_cnt: got %0d want 5", obs_ret[12]); else n_pass++;
  endtask

  task automatic test_illegal();
    int pulses;
    logic bad;
    pulses = 0;
    bad    = 1'b0;
    opcode = 6'h3F;
    @(posedge clk); #1;
    n_checks++; if (state !== S_DECODE) $display("FAIL ill_decode: got %0d want 2", state); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if ({state, halted, illegal_op} !== {S_HALT, 2'b11}) $display("FAIL ill_halt: got state=%0d halted=%b ill=%b want 13 1 1", state, halted, illegal_op); else n_pass++;
    n_checks++; if ({state_n, halted_n, illegal_op_n} !== {S_FETCH, 2'b01}) $display("FAIL ill_drop: got state=%0d halted=%b ill=%b want 1 0 1", state_n, halted_n, illegal_op_n); else n_pass++;
    n_checks++; if (halted_w !== 1'b1) $display("FAIL ill_halt_w: got %b want 1", halted_w); else n_pass++;
    n_checks++; if (instr_retired_n !== 32'd5) $display("FAIL ill_cnt_n: got %0d want 5", instr_retired_n); else n_pass++;
    opcode = 6'h00;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (illegal_op) pulses++;
      if (state !== S_HALT || halted !== 1'b1 || ctl !== C_IDLE) bad = 1'b1;
    end
    n_checks++; if (pulses != 0) $display("FAIL ill_pulse_once: extra pulses=%0d want 0", pulses); else n_pass++;
    n_checks++; if (bad !== 1'b0) $display("FAIL ill_hold: got unstable halt want steady"); else n_pass++;
    n_checks++; if (instr_retired !== 32'd5) $display("FAIL ill_cnt: got %0d want 5", instr_retired); else n_pass++;
  endtask

  task automatic test_reset_mid_write();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_steps = 0;
    add_step(S_IDLE,      C_IDLE,      6'h08, 1'b1);
    add_step(S_FETCH,     C_FETCH_RDY, 6'h08, 1'b1);
    add_step(S_DECODE,    C_DECODE,    6'h08, 1'b1);
    add_step(S_ADDI_EXEC, C_ADDI_EXEC, 6'h08, 1'b1);
    add_step(S_ADDI_WB,   C_ADDI_WB,   6'h08, 1'b1);
    add_step(S_FETCH,     C_FETCH_RDY, 6'h2B, 1'b1);
    add_step(S_DECODE,    C_DECODE,    6'h2B, 1'b1);
    add_step(S_MEM_ADDR,  C_MEM_ADDR,  6'h2B, 1'b0);
    add_step(S_MEM_WR,    C_MEM_WR,    6'h2B, 1'b0);
    add_step(S_MEM_WR,    C_MEM_WR,    6'h2B, 1'b0);
    play();
    for (int i = 0; i < n_steps; i++) begin
      n_checks++;
      if (obs_st[i] !== exp_st[i] || obs_ctl[i] !== exp_ctl[i])
        $display("FAIL rstw_step%0d: got state=%0d ctl=%h want state=%0d ctl=%h",
                 i, obs_st[i], obs_ctl[i], exp_st[i], exp_ctl[i]);
      else n_pass++;
    end
    n_checks++; if (obs_ret[9] !== 32'd1) $display("FAIL rstw_cnt_pre: got %0d want 1", obs_ret[9]); else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++; if (mem_write !== 1'b0) $display("FAIL rstw_mem_write: got %b want 0", mem_write); else n_pass++;
    n_checks++; if (state !== S_IDLE) $display("FAIL rstw_state: got %0d want 0", state); else n_pass++;
    n_checks++; if (instr_retired !== 32'd0) $display("FAIL rstw_cnt: got %0d want 0", instr_retired); else n_pass++;
    n_checks++; if ({ctl, ctl_n, ctl_w} !== 48'd0) $display("FAIL rstw_ctl: got %h want 0", {ctl, ctl_n, ctl_w}); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_checks++; if (state !== S_IDLE) $display("FAIL rstw_release: got %0d want 0", state); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (state !== S_FETCH) $display("FAIL rstw_fetch: got %0d want 1", state); else n_pass++;
  endtask

  task automatic test_wrap();
    opcode    = 6'h08;
    mem_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      repeat (4) begin
        @(posedge clk); #1;
      end
      if (k == 14) begin
        n_checks++; if (instr_retired_w !== 4'd15) $display("FAIL wrap_15: got %0d want 15", instr_retired_w); else n_pass++;
      end
    end
    n_checks++; if (instr_retired_w !== 4'd0) $display("FAIL wrap_0: got %0d want 0", instr_retired_w); else n_pass++;
    n_checks++; if (instr_retired !== 32'd16) $display("FAIL wrap_wide: got %0d want 16", instr_retired); else n_pass++;
    n_checks++; if (state !== S_FETCH) $display("FAIL wrap_state: got %0d want 1", state); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_stall();
    test_back_to_back();
    test_illegal();
    test_reset_mid_write();
    test_wrap();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle MIPS control FSM. It sequences a shared-ALU, shared-memory datapath through fetch, decode, execute, memory and writeback steps, one state per cycle. Memory accesses use a ready handshake so that variable-latency memory stalls the FSM. The block replaces single-cycle opcode decode in the multi-cycle core and adds a retired-instruction counter and illegal-opcode trapping.

Parameters:
CNT_W, 32, width of the instr_retired counter.
ILLEGAL_HALT, 1. 1: an illegal opcode enters HALT. 0: an illegal opcode is dropped and the FSM returns to FETCH.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
opcode  in  6  IR[31:26]; stable from DECODE until the instruction ends
mem_ready  in  1  memory completes the current read/write this cycle
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero
iord  out  1  memory address: 0 = PC, 1 = ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  IR load
mem_2_reg  out  1  register write data: 1 = MDR, 0 = ALUOut
reg_dst  out  1  destination register: 1 = rd, 0 = rt
reg_write  out  1  register file write enable
alu_src_a  out  1  0 = PC, 1 = reg A
alu_src_b  out  2  00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
alu_op  out  2  00 = add, 01 = sub, 10 = R-type funct decode
pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
illegal_op  out  1  one-cycle pulse on illegal opcode
halted  out  1  FSM is in HALT
instr_retired  out  CNT_W  count of completed instructions
state  out  4  current state, for debug

Behaviour:
- Outputs are Moore decodes of the state register, except that ir_write and pc_write in FETCH are qualified by mem_ready. Any signal not listed for a state is 0.
- Reset (async): state = IDLE (0), instr_retired = 0, illegal_op = 0. Every output is 0 while rst is high.
- IDLE: all outputs 0. Next cycle goes to FETCH.
- FETCH (1): mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00, ir_write=mem_ready, pc_write=mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE (2): alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 0x23 or 0x2B: MEM_ADDR
  - 0x00: R_EXEC
  - 0x04: BEQ
  - 0x02: JMP
  - 0x08: ADDI_EXEC
  - other: illegal_op pulses for 1 cycle; next is HALT if ILLEGAL_HALT else FETCH. An illegal instruction is not counted.
- MEM_ADDR (3): alu_src_a=1, alu_src_b=10, alu_op=00. Next is MEM_RD for 0x23, MEM_WR for 0x2B.
- MEM_RD (4): mem_read=1, iord=1. Waits for mem_ready, then MEM_WB.
- MEM_WB (5): reg_write=1, mem_2_reg=1, reg_dst=0. Next FETCH.
- MEM_WR (6): mem_write=1, iord=1. Waits for mem_ready, then FETCH.
- R_EXEC (7): alu_src_a=1, alu_src_b=00, alu_op=10. Next R_WB.
- R_WB (8): reg_write=1, reg_dst=1, mem_2_reg=0. Next FETCH.
- BEQ (9): alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01. Next FETCH.
- JMP (10): pc_write=1, pc_source=10. Next FETCH.
- ADDI_EXEC (11): alu_src_a=1, alu_src_b=10, alu_op=00. Next ADDI_WB.
- ADDI_WB (12): reg_write=1, reg_dst=0, mem_2_reg=0. Next FETCH.
- HALT (13): all control outputs 0, halted=1. Left only by reset.
- Unused state encodings go to IDLE.
- instr_retired increments by 1, with wrap-around modulo 2^CNT_W, on each transition into FETCH from MEM_WB, MEM_WR, R_WB, BEQ, JMP or ADDI_WB.
- mem_read and mem_write are never both 1. A request stays asserted, with iord stable, until the cycle mem_ready=1. mem_ready is ignored in all states except FETCH, MEM_RD and MEM_WR.
- Reset mid-instruction, including during a memory wait, drops every output to 0 immediately (combinationally with rst). No write enable may glitch high.
- Latency with mem_ready tied to 1, in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Decomposition:
- Package mips_ctrl_pkg holds the opcode constants, the alu_op codes (ADD/SUB/R_TYPE), the alu_src_b and pc_source select encodings, and the state encodings. The single-cycle control unit uses the same package.
- No sub-module is needed. The counter stays inline.

Test Plan:
- Reset, then add (opcode 0x00) with mem_ready=1: states IDLE,FETCH,DECODE,R_EXEC,R_WB,FETCH. reg_write=1 and reg_dst=1 only in R_WB. instr_retired goes 0 to 1.
- lw (0x23) with mem_ready low for 3 cycles in MEM_RD: mem_read=1 and iord=1 held 4 cycles. MEM_WB has mem_2_reg=1, reg_write=1. Total 8 cycles; counter +1.
- sw (0x2B) then beq (0x04) then j (0x02): mem_write=1 only in MEM_WR. BEQ cycle has pc_write_cond=1, pc_source=01, alu_op=01. JMP cycle has pc_write=1, pc_source=10. Counter +3.
- Opcode 0x3F with ILLEGAL_HALT=1: illegal_op pulses once, halted=1 and stays there with all writes 0 for 20 cycles; counter unchanged. With ILLEGAL_HALT=0: returns to FETCH.
- Assert rst during a MEM_WR wait: mem_write drops to 0 in the same cycle, state=0 and counter=0. After rst falls, FETCH follows one cycle later.
- CNT_W=4 with 16 addi (0x08) instructions: counter wraps from 15 to 0. ADDI_WB has reg_dst=0, reg_write=1.
